systolic_array_param: RTL and testbench
=======================================

SYSTOLIC_ARRAY_PARAM -- requirements
Module: systolic_array_param

Interface
REQ-001 Parameter ROWS, default 8: array rows, equal to dot-product depth; legal range 2..32.
REQ-002 Parameter COLS, default 8: array columns, equal to output channels; legal range 2..32.
REQ-003 Parameter ACT_W, default 4: activation width.
REQ-004 Parameter WGT_W, default 8: weight width.
REQ-005 Parameter ACC_W, default 32: accumulator width; legal only if ACC_W >= ACT_W+WGT_W.
REQ-006 Parameter ACT_SIGNED, default 1: 1 means activations are two's complement, 0 means unsigned; weights are always signed.
REQ-007 clk  input  1  single clock; all state changes on the rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 w_start  input  1  request a weight (re)load.
REQ-010 w_valid  input  1  weight row beat valid.
REQ-011 w_in  input  COLS*WGT_W  weight row; column c is at [c*WGT_W +: WGT_W].
REQ-012 a_valid  input  1  activation vector valid.
REQ-013 a_ready  output  1  activation vector accepted when a_valid and a_ready are both high.
REQ-014 a_in  input  ROWS*ACT_W  activation vector; row r is at [r*ACT_W +: ACT_W].
REQ-015 y_valid  output  1  result vector valid; there is no output backpressure.
REQ-016 y_data  output  COLS*ACC_W  result vector; column c is at [c*ACC_W +: ACC_W].
REQ-017 busy  output  1  high in LOAD or DRAIN.
REQ-018 load_done  output  1  one-cycle pulse when the final weight row is written.

Function
REQ-019 The FSM SHALL have four states, IDLE, LOAD, COMPUTE and DRAIN, with these transitions:
- IDLE to LOAD on w_start.
- LOAD to COMPUTE after ROWS accepted w_valid beats.
- COMPUTE to DRAIN on w_start.
- DRAIN to LOAD when no accepted vector remains in flight.
REQ-020 In LOAD, the k-th w_valid beat (k = 0..ROWS-1) SHALL write w_in into weight row k; w_valid outside LOAD is ignored.
REQ-021 w_start in LOAD or DRAIN SHALL be ignored.
REQ-022 load_done SHALL pulse in the cycle of the write to row ROWS-1.
REQ-023 a_ready SHALL be 1 exactly when the state is COMPUTE.
REQ-024 If w_start and an a_valid handshake occur in the same COMPUTE cycle, the vector SHALL be accepted and included in the drain.
REQ-025 Dataflow is weight-stationary:
- PE(r,c) holds W[r][c].
- PE(r,c) registers the activation it passes to PE(r,c+1).
- PE(r,c) registers psum_out = psum_in + a*W[r][c].
- The psum into row 0 is zero.
REQ-026 The block SHALL contain an input skew: row r of an accepted vector enters column 0 delayed by r cycles relative to row 0.
REQ-027 The block SHALL contain an output deskew: column c delays by (COLS-1-c) cycles, so all columns of one vector emerge in the same cycle.
REQ-028 Latency: a vector accepted at cycle t SHALL appear on y_data with y_valid=1 at cycle t+LAT, where LAT = ROWS+COLS.
REQ-029 Throughput SHALL be one vector per cycle; accepted vectors emerge in order with no gaps other than the input gaps.
REQ-030 Cycles without a handshake SHALL inject a bubble: y_valid=0 at the matching output cycle, and y_data is don't-care.
REQ-031 Result: y_data[c] = sum over r of a[r]*W[r][c].
- Activations are extended per ACT_SIGNED; weights are sign-extended.
- Arithmetic is modulo 2^ACC_W (wrap, no saturation).
REQ-032 In-flight tracking SHALL be a LAT-deep valid shift register; DRAIN exits in the first cycle it is all zero.
- Exit is immediate if it is already zero.
- All in-flight vectors are output using the old weights.
REQ-033 Weights SHALL change only in LOAD.

Reset
REQ-034 On rst the block SHALL asynchronously enter IDLE and clear all weights, pipeline, skew and deskew registers and the valid chain.
REQ-035 While rst is high: a_ready=0, y_valid=0, y_data=0, busy=0, load_done=0.
REQ-036 Reset mid-LOAD or mid-DRAIN SHALL discard partial weights and in-flight vectors; no y_valid follows reset release until new vectors are accepted.

Verification
REQ-037 Load: ROWS=COLS=4, ACT_W=4, WGT_W=8, ACT_SIGNED=1.
- W[r][c] = r+c+1; w_start, then 4 w_valid beats.
- Expect busy=1 in LOAD, load_done on the 4th beat, then a_ready=1.
REQ-038 Single vector: a = {1,2,3,4} accepted at cycle t.
- Expect y_valid at t+8 only.
- Expect y_data = {30,40,50,60}.
REQ-039 Streaming: 20 back-to-back random vectors, then 3 bubbles, then 5 more.
- Expect 25 in-order results matching the reference model.
- Expect 3 y_valid=0 cycles aligned to the bubbles.
REQ-040 Signed/wrap:
- a = all -8, W = all -128, ACC_W=16: expect each column = 4096.
- ACT_SIGNED=0 with a = all 15: expect each column = 4*15*(-128) = -7680.
REQ-041 Reload under traffic: w_start in the same cycle as the 10th accepted vector.
- Expect a_ready=0 from the next cycle; vectors 1-10 output with the old weights.
- Expect LOAD entered only after the last y_valid.
- Expect new weights used afterwards.
REQ-042 Reset: rst asserted mid-stream with 5 vectors in flight.
- Expect all outputs 0 immediately and no stale y_valid after release.
- Expect the state is IDLE and a_ready=0 until a new load completes.

Source files
------------

// File: rtl/systolic_array_param.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_param
// Description : Weight-stationary ROWS x COLS systolic matrix-vector engine.
//               Weights are loaded one row per beat. Activation vectors are
//               then streamed in at one per cycle, and each vector's dot
//               products leave the array aligned in one output word.
// Ports       : clk, rst                - clock, async active-high reset
//               w_start, w_valid, w_in  - weight (re)load request and row beats
//               a_valid, a_ready, a_in  - activation vector handshake
//               y_valid, y_data         - result vector (no backpressure)
//               busy, load_done         - LOAD/DRAIN status, last-row pulse
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_param #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ACT_W      = 4,
    parameter int WGT_W      = 8,
    parameter int ACC_W      = 32,
    parameter int ACT_SIGNED = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_start,
    input  logic                    w_valid,
    input  logic [COLS*WGT_W-1:0]   w_in,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [ROWS*ACT_W-1:0]   a_in,
    output logic                    y_valid,
    output logic [COLS*ACC_W-1:0]   y_data,
    output logic                    busy,
    output logic                    load_done
);

    localparam int              c_LAT      = ROWS + COLS;
    localparam int              c_CW       = $clog2(ROWS);
    localparam logic [c_CW-1:0] c_LAST_ROW = c_CW'(ROWS - 1);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_LOAD    = 2'd1;
    localparam logic [1:0] c_S_COMPUTE = 2'd2;
    localparam logic [1:0] c_S_DRAIN   = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_CW-1:0]        r_row_cnt;
    logic [c_LAT-1:0]       r_vld;
    logic                   w_accept;
    logic                   w_wgt_wr;
    logic [ROWS*ACT_W-1:0]  w_a_gated;

    // Activation entering each PE and partial sum leaving each PE.
    logic [ACT_W-1:0]       w_act  [ROWS][COLS];
    logic [ACC_W-1:0]       w_psum [ROWS][COLS];

    assign w_accept  = a_valid && (r_state == c_S_COMPUTE);
    assign w_wgt_wr  = w_valid && (r_state == c_S_LOAD);
    // Non-accepted cycles push zeros so bubbles carry no stale data.
    assign w_a_gated = w_accept ? a_in : '0;
    assign y_valid   = r_vld[c_LAT-1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        a_ready     = 1'b0;
        busy        = 1'b0;
        load_done   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                busy = 1'b1;
                if (w_valid && (r_row_cnt == c_LAST_ROW)) begin
                    load_done   = 1'b1;
                    w_state_nxt = c_S_COMPUTE;
                end
            end
            c_S_COMPUTE: begin
                a_ready = 1'b1;
                if (w_start) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                busy = 1'b1;
                // Leave as soon as nothing accepted remains in the pipe.
                if (r_vld == '0) begin
                    w_state_nxt = c_S_LOAD;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Weight row pointer: restarts at 0 whenever a load begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_cnt <= '0;
        end else if (r_state != c_S_LOAD) begin
            r_row_cnt <= '0;
        end else if (w_valid) begin
            r_row_cnt <= r_row_cnt + c_CW'(1);
        end
    end

    // In-flight tracker: one bit per accepted vector, aligned with the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[c_LAT-2:0], w_accept};
        end
    end

    // ------------------------------------------------------------------
    // Input skew: row r reaches column 0 r cycles after row 0.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign w_act[0][0] = w_a_gated[0 +: ACT_W];
        end else begin : g_delay
            logic [ACT_W-1:0] r_sr [r];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) begin
                        r_sr[k] <= '0;
                    end
                end else begin
                    r_sr[0] <= w_a_gated[r*ACT_W +: ACT_W];
                    for (int k = 1; k < r; k++) begin
                        r_sr[k] <= r_sr[k-1];
                    end
                end
            end
            assign w_act[r][0] = r_sr[r-1];
        end
    end

    // ------------------------------------------------------------------
    // Processing elements
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [WGT_W-1:0] r_wgt;
            logic        [ACC_W-1:0] r_psum;
            logic signed [ACT_W:0]   w_a_ext;
            logic signed [ACC_W-1:0] w_prod;
            logic        [ACC_W-1:0] w_psum_in;

            // One extra bit makes unsigned activations safe to treat as signed.
            assign w_a_ext = (ACT_SIGNED != 0) ? {w_act[r][c][ACT_W-1], w_act[r][c]}
                                               : {1'b0, w_act[r][c]};
            // Low ACC_W bits of the extended product give modulo-2^ACC_W math.
            assign w_prod  = ACC_W'(w_a_ext) * ACC_W'(r_wgt);

            if (r == 0) begin : g_top
                assign w_psum_in = '0;
            end else begin : g_chain
                assign w_psum_in = w_psum[r-1][c];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wgt  <= '0;
                    r_psum <= '0;
                end else begin
                    r_psum <= w_psum_in + w_prod;
                    if (w_wgt_wr && (r_row_cnt == c_CW'(r))) begin
                        r_wgt <= w_in[c*WGT_W +: WGT_W];
                    end
                end
            end
            assign w_psum[r][c] = r_psum;

            // The last column has no neighbour, so it forwards nothing.
            if (c < COLS-1) begin : g_fwd
                logic [ACT_W-1:0] r_act;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_act <= '0;
                    end else begin
                        r_act <= w_act[r][c];
                    end
                end
                assign w_act[r][c+1] = r_act;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output deskew: column c waits COLS-1-c cycles plus one shared output
    // register stage, so every column of a vector lands in the same cycle.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int c_DEPTH = COLS - c;
        logic [ACC_W-1:0] r_dly [c_DEPTH];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < c_DEPTH; k++) begin
                    r_dly[k] <= '0;
                end
            end else begin
                r_dly[0] <= w_psum[ROWS-1][c];
                for (int k = 1; k < c_DEPTH; k++) begin
                    r_dly[k] <= r_dly[k-1];
                end
            end
        end
        assign y_data[c*ACC_W +: ACC_W] = r_dly[c_DEPTH-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_param
// Description : Directed bench for systolic_array_param at 4x4. Covers load,
//               a single vector, streaming with bubbles, reload under traffic,
//               mid-stream reset, and signed/unsigned wrap on 16-bit variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_param;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ACT_W = 4;
    localparam int WGT_W = 8;
    localparam int LAT   = ROWS + COLS;

    logic         clk = 1'b0;
    logic         rst;
    logic         w_start, w_valid, a_valid;
    logic [31:0]  w_in;
    logic [15:0]  a_in;
    logic         a_ready, y_valid, busy, load_done;
    logic [127:0] y_data;
    logic         s_a_ready, s_y_valid, s_busy, s_load_done;
    logic [63:0]  s_y_data;
    logic         u_a_ready, u_y_valid, u_busy, u_load_done;
    logic [63:0]  u_y_data;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    bit           mon_en   = 1'b0;
    bit           exp_v [0:4095];
    logic [127:0] exp_d [0:4095];
    int           wm [ROWS][COLS];
    int           t0, last;

    systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .ACT_W(ACT_W), .WGT_W(WGT_W),
                           .ACC_W(32), .ACT_SIGNED(1)) dut (
        .clk(clk), .rst(rst), .w_start(w_start), .w_valid(w_valid), .w_in(w_in),
        .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in), .y_valid(y_valid),
        .y_data(y_data), .busy(busy), .load_done(load_done));

    systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .ACT_W(ACT_W), .WGT_W(WGT_W),
                           .ACC_W(16), .ACT_SIGNED(1)) dut_s16 (
        .clk(clk), .rst(rst), .w_start(w_start), .w_valid(w_valid), .w_in(w_in),
        .a_valid(a_valid), .a_ready(s_a_ready), .a_in(a_in), .y_valid(s_y_valid),
        .y_data(s_y_data), .busy(s_busy), .load_done(s_load_done));

    systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .ACT_W(ACT_W), .WGT_W(WGT_W),
                           .ACC_W(16), .ACT_SIGNED(0)) dut_u16 (
        .clk(clk), .rst(rst), .w_start(w_start), .w_valid(w_valid), .w_in(w_in),
        .a_valid(a_valid), .a_ready(u_a_ready), .a_in(a_in), .y_valid(u_y_valid),
        .y_data(u_y_data), .busy(u_busy), .load_done(u_load_done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model(input logic [15:0] a);
        logic [127:0] y;
        int s;
        y = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) begin
                s += int'($signed(a[r*4 +: 4])) * wm[r][c];
            end
            y[c*32 +: 32] = s;
        end
        return y;
    endfunction

    function automatic logic [31:0] wrow(input int k);
        logic [31:0] v;
        for (int c = 0; c < COLS; c++) begin
            v[c*8 +: 8] = 8'(wm[k][c]);
        end
        return v;
    endfunction

    task automatic send(input logic [15:0] a);
        a_valid = 1'b1;
        a_in    = a;
        exp_v[cyc+LAT] = 1'b1;
        exp_d[cyc+LAT] = model(a);
        tick();
        a_valid = 1'b0;
    endtask

    // from_compute: one DRAIN cycle (empty pipe) separates w_start and LOAD.
    task automatic load(input bit from_compute);
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        if (from_compute) begin
            chk("drain_busy", 128'(busy), 128'(1));
            chk("drain_ready", 128'(a_ready), 128'(0));
            tick();
        end
        for (int k = 0; k < ROWS; k++) begin
            w_valid = 1'b1;
            w_in    = wrow(k);
            #1;
            chk("load_busy", 128'(busy), 128'(1));
            chk("load_ready", 128'(a_ready), 128'(0));
            chk("load_done", 128'(load_done), 128'(k == ROWS-1));
            tick();
        end
        w_valid = 1'b0;
        chk("ready_after_load", 128'(a_ready), 128'(1));
        chk("busy_after_load", 128'(busy), 128'(0));
    endtask

    // Every cycle: y_valid must match the schedule; data checked where valid.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("y_valid", 128'(y_valid), 128'(exp_v[cyc]));
            if (exp_v[cyc]) chk("y_data", y_data, exp_d[cyc]);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = '0;
        end
        rst = 1'b1; w_start = 1'b0; w_valid = 1'b0; w_in = '0; a_valid = 1'b0; a_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_ready", 128'(a_ready), 128'(0));
        chk("rst_y_valid", 128'(y_valid), 128'(0));
        chk("rst_y_data", y_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_load_done", 128'(load_done), 128'(0));
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
        chk("idle_ready", 128'(a_ready), 128'(0));

        // Stray beat in IDLE must not advance the row pointer.
        w_valid = 1'b1; w_in = '1;
        tick();
        w_valid = 1'b0;

        // Load W[r][c] = r+c+1.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = r + c + 1;
        load(1'b0);
        chk("aux_ctrl", 128'({s_a_ready, s_busy, s_load_done, u_a_ready, u_busy, u_load_done}),
            128'(6'b100100));

        // Single vector a = {1,2,3,4}: hand-computed {30,40,50,60}.
        a_valid = 1'b1; a_in = 16'h4321;
        exp_v[cyc+LAT] = 1'b1;
        exp_d[cyc+LAT] = {32'd60, 32'd50, 32'd40, 32'd30};
        tick();
        a_valid = 1'b0;
        repeat (12) tick();

        // Streaming: 20 back-to-back, 3 bubbles, 5 more.
        for (int i = 0; i < 20; i++) send(16'($urandom));
        a_in = 16'h5A5A;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) send(16'($urandom));
        repeat (12) tick();

        // Reload under traffic: w_start alongside the 10th accepted vector.
        for (int i = 0; i < 9; i++) send(16'($urandom));
        a_valid = 1'b1; a_in = 16'h9C3E; w_start = 1'b1;
        t0 = cyc;
        exp_v[cyc+LAT] = 1'b1;
        exp_d[cyc+LAT] = model(16'h9C3E);
        tick();
        w_start = 1'b0;
        // Offered vectors and weight beats during DRAIN must both be ignored.
        a_in = 16'h7777; w_valid = 1'b1; w_in = 32'hA5A5A5A5;
        last = t0 + LAT;
        while (cyc < last + 2) begin
            chk("drain_a_ready", 128'(a_ready), 128'(0));
            chk("drain_busy_t", 128'(busy), 128'(1));
            chk("drain_load_done", 128'(load_done), 128'(0));
            tick();
        end
        a_valid = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = r*4 + c - 7;
        for (int k = 0; k < ROWS; k++) begin
            w_valid = 1'b1;
            w_in    = wrow(k);
            #1;
            chk("reload_busy", 128'(busy), 128'(1));
            chk("reload_done", 128'(load_done), 128'(k == ROWS-1));
            tick();
        end
        w_valid = 1'b0;
        chk("reload_ready", 128'(a_ready), 128'(1));
        send(16'h4321);
        send(16'h8F17);
        send(16'h3CA5);
        repeat (12) tick();

        // Reset with 5 vectors in flight.
        for (int i = 0; i < 5; i++) send(16'($urandom));
        rst = 1'b1;
        for (int k = cyc; k < cyc + LAT + 4; k++) exp_v[k] = 1'b0;
        #1;
        chk("mid_rst_a_ready", 128'(a_ready), 128'(0));
        chk("mid_rst_y_valid", 128'(y_valid), 128'(0));
        chk("mid_rst_y_data", y_data, 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_load_done", 128'(load_done), 128'(0));
        tick();
        tick();
        rst = 1'b0;
        repeat (12) begin
            chk("post_rst_ready", 128'(a_ready), 128'(0));
            chk("post_rst_busy", 128'(busy), 128'(0));
            tick();
        end
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = r + c + 1;
        load(1'b0);
        send(16'h4321);
        send(16'($urandom));
        repeat (12) tick();

        // Signed / wrap on the 16-bit variants, W = all -128.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = -128;
        load(1'b1);
        send(16'h8888);
        send(16'hFFFF);
        repeat (LAT - 2) tick();
        chk("s16_valid_a8", 128'(s_y_valid), 128'(1));
        chk("s16_data_a8", 128'(s_y_data), 128'({4{16'h1000}}));
        chk("u16_valid_a8", 128'(u_y_valid), 128'(1));
        chk("u16_data_a8", 128'(u_y_data), 128'({4{16'hF000}}));
        tick();
        chk("s16_data_af", 128'(s_y_data), 128'({4{16'h0200}}));
        chk("u16_data_af", 128'(u_y_data), 128'({4{16'hE200}}));
        repeat (4) tick();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
